// File: rtl/cmos_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmos_pkg                                                             |
// | FSM encoding, counter widths and parameter defaults for the CMOS     |
// | capture controller.                                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cmos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_WAIT_VS = 2'd2,
    ST_CAPTURE = 2'd3
  } cap_state_t;

  localparam int unsigned C_SKIP_FRAMES_DEF = 10;
  localparam int unsigned C_H_BYTES_DEF     = 2560;
  localparam int unsigned C_V_LINES_DEF     = 720;

  localparam int C_BYTE_W = 12;
  localparam int C_LINE_W = 11;
  localparam int C_SKIP_W = 16;

endpackage
`default_nettype wire

// File: rtl/cmos_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmos_edge_det                                                        |
// | One-flop history of a registered level with rise/fall strobes.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cmos_edge_det (
  input  logic pclk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;
  assign o_fall = ~i_d & r_prev;

endmodule
`default_nettype wire

// File: rtl/cmos_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmos_capture_ctrl                                                    |
// | Gates sensor bytes into whole frames after a skip period and reports |
// | per-frame size status. Revision: 1.0                                 |
// +----------------------------------------------------------------------+
module cmos_capture_ctrl
  import cmos_pkg::*;
#(
  parameter int unsigned SKIP_FRAMES = C_SKIP_FRAMES_DEF,
  parameter int unsigned H_BYTES     = C_H_BYTES_DEF,
  parameter int unsigned V_LINES     = C_V_LINES_DEF
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       cfg_done,
  input  logic       cap_en,
  input  logic       vs_i,
  input  logic       href_i,
  input  logic [7:0] pdata_i,
  output logic       vs_o,
  output logic       de_o,
  output logic [7:0] pdata_o,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  logic                r_vs;
  logic                r_href;
  logic [7:0]          r_pdata;
  cap_state_t          r_state;
  logic [C_SKIP_W-1:0] r_skip_cnt;
  logic [C_BYTE_W-1:0] r_byte_cnt;
  logic [C_LINE_W-1:0] r_line_cnt;
  logic                r_line_err;
  logic                r_frame_start;
  logic                r_frame_done;
  logic                r_frame_err;
  logic [7:0]          r_frame_cnt;

  logic                w_vs_rise;
  logic                w_vs_fall;
  logic                w_href_rise;
  logic                w_href_fall;
  logic                w_capture;
  logic                w_line_end;
  logic                w_byte_max;
  logic                w_line_max;
  logic                w_err_now;
  logic [C_LINE_W-1:0] w_lines_now;
  logic                w_frame_err;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs    <= 1'b0;
      r_href  <= 1'b0;
      r_pdata <= 8'd0;
    end else begin
      r_vs    <= vs_i;
      r_href  <= href_i;
      r_pdata <= pdata_i;
    end
  end

  cmos_edge_det u_vs_edge (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .i_d    (r_vs),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  cmos_edge_det u_href_edge (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .i_d    (r_href),
    .o_rise (w_href_rise),
    .o_fall (w_href_fall)
  );

  assign w_capture  = (r_state == ST_CAPTURE);
  assign w_line_end = w_href_fall & w_capture;
  assign w_byte_max = &r_byte_cnt;
  assign w_line_max = &r_line_cnt;

  // Status as it stands including this cycle's line end, so a line closing
  // together with the vs rise is still counted in the frame result.
  assign w_err_now   = r_line_err
                     | (w_line_end & (32'(r_byte_cnt) != H_BYTES))
                     | (de_o & w_byte_max)
                     | (w_line_end & w_line_max);
  assign w_lines_now = (w_line_end && !w_line_max) ? r_line_cnt + 11'd1 : r_line_cnt;
  assign w_frame_err = w_err_now | (32'(w_lines_now) != V_LINES);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_skip_cnt    <= '0;
      r_byte_cnt    <= '0;
      r_line_cnt    <= '0;
      r_line_err    <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else begin
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      if (!cfg_done) begin
        r_state    <= ST_IDLE;
        r_skip_cnt <= '0;
        r_byte_cnt <= '0;
        r_line_cnt <= '0;
        r_line_err <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_SKIP;
            r_skip_cnt <= '0;
          end
          ST_SKIP: begin
            if (SKIP_FRAMES == 0) begin
              r_state <= ST_WAIT_VS;
            end else if (w_vs_rise) begin
              if (32'(r_skip_cnt) == SKIP_FRAMES - 1) begin
                r_state <= ST_WAIT_VS;
              end else begin
                r_skip_cnt <= r_skip_cnt + 1'b1;
              end
            end
          end
          ST_WAIT_VS: begin
            if (w_vs_fall && cap_en) begin
              r_state       <= ST_CAPTURE;
              r_frame_start <= 1'b1;
              r_byte_cnt    <= '0;
              r_line_cnt    <= '0;
              r_line_err    <= 1'b0;
            end
          end
          ST_CAPTURE: begin
            if (w_vs_rise) begin
              r_state      <= ST_WAIT_VS;
              r_frame_done <= 1'b1;
              r_frame_err  <= w_frame_err;
              r_frame_cnt  <= r_frame_cnt + 8'd1;
              r_byte_cnt   <= '0;
              r_line_cnt   <= '0;
              r_line_err   <= 1'b0;
            end else begin
              if (w_href_rise) begin
                r_byte_cnt <= {{(C_BYTE_W-1){1'b0}}, de_o};
              end else if (w_href_fall) begin
                r_byte_cnt <= '0;
              end else if (de_o && !w_byte_max) begin
                r_byte_cnt <= r_byte_cnt + 12'd1;
              end
              r_line_cnt <= w_lines_now;
              r_line_err <= w_err_now;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign vs_o        = r_vs;
  assign pdata_o     = r_pdata;
  assign de_o        = r_href & w_capture & ~r_vs;
  assign busy        = w_capture;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign frame_err   = r_frame_err;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmos_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cmos_capture_ctrl                                                 |
// | Scoreboard bench: expected bytes/frame results queued at drive time. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cmos_capture_ctrl;

  localparam int unsigned SKIP = 2;
  localparam int unsigned HB   = 8;
  localparam int unsigned VL   = 4;

  typedef struct packed {
    logic       err;
    logic [7:0] cnt;
  } fexp_t;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cap_en = 1'b0;
  logic       vs_i = 1'b1;
  logic       href_i = 1'b0;
  logic [7:0] pdata_i = 8'h3C;
  logic       vs_o, de_o, frame_start, frame_done, frame_err, busy;
  logic [7:0] pdata_o, frame_cnt;

  fexp_t      frame_q[$];
  logic [7:0] byte_q[$];
  fexp_t      mon_e;
  logic [7:0] exp_cnt = 8'd0;
  int         exp_starts = 0;
  int         n_starts = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic       m_vs;
  logic [7:0] m_pd;

  cmos_capture_ctrl #(
    .SKIP_FRAMES (SKIP),
    .H_BYTES     (HB),
    .V_LINES     (VL)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .cfg_done    (cfg_done),
    .cap_en      (cap_en),
    .vs_i        (vs_i),
    .href_i      (href_i),
    .pdata_i     (pdata_i),
    .vs_o        (vs_o),
    .de_o        (de_o),
    .pdata_o     (pdata_o),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference for the ungated 1-cycle pass-through of vsync and data.
  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      m_vs <= 1'b0;
      m_pd <= 8'd0;
    end else begin
      m_vs <= vs_i;
      m_pd <= pdata_i;
    end
  end

  always @(negedge pclk) begin
    if (rst_n) begin
      check_val("vs_o", vs_o, m_vs);
      check_val("pdata_o", pdata_o, m_pd);
      if (de_o) begin
        if (byte_q.size() == 0) check_val("de_unexp", 1, 0);
        else check_val("de_byte", pdata_o, byte_q.pop_front());
      end
      if (frame_start) begin
        n_starts++;
        check_val("start_busy", busy, 1);
      end
      if (frame_done) begin
        if (frame_q.size() == 0) begin
          check_val("fdone_unexp", 1, 0);
        end else begin
          mon_e = frame_q.pop_front();
          check_val("fdone_err", frame_err, mon_e.err);
          check_val("fdone_cnt", frame_cnt, mon_e.cnt);
          check_val("fdone_busy", busy, 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_line(input int nb, input bit exp, input bit vs_at_end);
    for (int i = 0; i < nb; i++) begin
      step();
      href_i  = 1'b1;
      pdata_i = 8'($urandom);
      if (exp) byte_q.push_back(pdata_i);
    end
    step();
    href_i = 1'b0;
    if (vs_at_end) vs_i = 1'b1;
    else idle(3);
  endtask

  task automatic frame_open();
    step();
    vs_i = 1'b0;
    idle(3);
  endtask

  task automatic frame_close(input bit exp, input bit err);
    step();
    vs_i = 1'b1;
    if (exp) begin
      exp_cnt = exp_cnt + 8'd1;
      frame_q.push_back('{err: err, cnt: exp_cnt});
      exp_starts++;
    end
    idle(5);
  endtask

  task automatic frame(input bit exp, input int nlines, input int short_idx, input bit coin);
    frame_open();
    for (int l = 0; l < nlines; l++)
      send_line((l == short_idx) ? 7 : 8, exp, coin && (l == nlines - 1));
    frame_close(exp, (short_idx >= 0 && short_idx < nlines) || (nlines != 4));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check_val("rst_vs_o", vs_o, 0);
    check_val("rst_de_o", de_o, 0);
    check_val("rst_pdata_o", pdata_o, 0);
    check_val("rst_fstart", frame_start, 0);
    check_val("rst_fdone", frame_done, 0);
    check_val("rst_ferr", frame_err, 0);
    check_val("rst_fcnt", frame_cnt, 0);
    check_val("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(5);
    cfg_done = 1'b1;
    cap_en   = 1'b1;
    idle(3);

    // Two skipped frames, then continuous capture.
    frame(0, 4, -1, 0);
    frame(0, 4, -1, 0);
    frame(1, 4, -1, 0);
    frame(1, 4, -1, 0);

    // Size errors and their recovery, including line/vsync coincidence.
    frame(1, 4, 1, 0);
    frame(1, 4, -1, 0);
    frame(1, 3, -1, 0);
    frame(1, 4, -1, 1);
    frame(1, 4, 3, 1);

    // cap_en drop mid-frame: frame completes, next is not captured.
    frame_open();
    send_line(8, 1, 0);
    send_line(8, 1, 0);
    cap_en = 1'b0;
    send_line(8, 1, 0);
    send_line(8, 1, 0);
    frame_close(1, 0);
    frame(0, 4, -1, 0);

    // cap_en raised mid-frame: wait for the next vsync fall.
    frame_open();
    send_line(8, 0, 0);
    cap_en = 1'b1;
    for (int l = 0; l < 3; l++) send_line(8, 0, 0);
    frame_close(0, 0);
    frame(1, 4, -1, 0);

    // cfg_done drop mid-line of a captured frame.
    frame_open();
    exp_starts++;
    send_line(8, 1, 0);
    send_line(8, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      href_i  = 1'b1;
      pdata_i = 8'($urandom);
      byte_q.push_back(pdata_i);
    end
    step();
    cfg_done = 1'b0;
    pdata_i  = 8'($urandom);
    step();
    check_val("cfgdrop_de", de_o, 0);
    check_val("cfgdrop_busy", busy, 0);
    idle(2);
    step();
    href_i = 1'b0;
    idle(3);
    send_line(8, 0, 0);
    frame_close(0, 0);
    cfg_done = 1'b1;
    idle(2);
    frame(0, 4, -1, 0);
    frame(0, 4, -1, 0);
    frame(1, 4, -1, 0);

    // Run the frame counter through its wrap.
    while (exp_cnt != 8'd0) frame(1, 4, -1, 0);
    check_val("wrap_cnt", frame_cnt, 0);
    frame(1, 4, -1, 0);
    check_val("post_wrap_cnt", frame_cnt, 1);
    check_val("q_bytes_empty", byte_q.size(), 0);
    check_val("q_frames_empty", frame_q.size(), 0);

    // Asynchronous reset in the middle of a captured line.
    frame_open();
    exp_starts++;
    step();
    href_i  = 1'b1;
    pdata_i = 8'hA5;
    byte_q.push_back(pdata_i);
    step();
    pdata_i = 8'h5A;
    byte_q.push_back(pdata_i);
    @(posedge pclk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_vs_o", vs_o, 0);
    check_val("arst_de_o", de_o, 0);
    check_val("arst_pdata_o", pdata_o, 0);
    check_val("arst_fstart", frame_start, 0);
    check_val("arst_fdone", frame_done, 0);
    check_val("arst_ferr", frame_err, 0);
    check_val("arst_fcnt", frame_cnt, 0);
    check_val("arst_busy", busy, 0);
    byte_q.delete();
    frame_q.delete();
    href_i = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(4);
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_fcnt", frame_cnt, 0);
    check_val("start_count", n_starts, exp_starts);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmos_capture_ctrl.md
CMOS_CAPTURE_CTRL -- requirements
Module: cmos_capture_ctrl

Interface
REQ-001 The block SHALL have parameter SKIP_FRAMES, default 10: frames discarded after sensor configuration completes.
REQ-002 The block SHALL have parameter H_BYTES, default 2560: expected bytes per line (1280 px x 2).
REQ-003 The block SHALL have parameter V_LINES, default 720: expected lines per frame.
REQ-004 The block SHALL have port pclk, input, 1: sensor pixel clock; all logic in this domain.
REQ-005 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port cfg_done, input, 1: sensor register configuration complete (level).
REQ-007 The block SHALL have port cap_en, input, 1: capture enable (level).
REQ-008 The block SHALL have port vs_i, input, 1: sensor vsync, active-high during vertical blanking.
REQ-009 The block SHALL have port href_i, input, 1: sensor byte-valid / line active.
REQ-010 The block SHALL have port pdata_i, input, 8: sensor byte.
REQ-011 The block SHALL have port vs_o, output, 1: registered vsync to the 8-to-16 packer.
REQ-012 The block SHALL have port de_o, output, 1: gated byte-valid to the packer.
REQ-013 The block SHALL have port pdata_o, output, 8: registered byte to the packer.
REQ-014 The block SHALL have port frame_start, output, 1: one-cycle pulse at the first gated frame's vs falling edge.
REQ-015 The block SHALL have port frame_done, output, 1: one-cycle pulse when a captured frame ends.
REQ-016 The block SHALL have port frame_err, output, 1: status valid with frame_done; 1 = size mismatch.
REQ-017 The block SHALL have port frame_cnt, output, 8: count of completed captured frames; wraps 255->0.
REQ-018 The block SHALL have port busy, output, 1: high in CAPTURE state.

Function
REQ-019 The block SHALL register vs_i, href_i and pdata_i once; vs_o and pdata_o SHALL follow the inputs with 1-cycle latency, ungated.
REQ-020 The block SHALL drive de_o = registered href_i AND (state == CAPTURE) AND vs low, so that de_o has 1-cycle latency.
REQ-021 The block SHALL detect vs rise and vs fall, and href fall, from the registered signals.
REQ-022 The FSM SHALL have states IDLE, SKIP, WAIT_VS and CAPTURE.
REQ-023 IDLE SHALL go to SKIP when cfg_done = 1, clearing the skip counter.
REQ-024 SKIP SHALL count vs rises and go to WAIT_VS on the SKIP_FRAMES-th rise; if SKIP_FRAMES = 0, it SHALL go to WAIT_VS directly.
REQ-025 WAIT_VS SHALL go to CAPTURE on a vs fall while cap_en = 1; frame_start SHALL pulse in the same cycle as the transition.
REQ-026 A frame that is already in progress when cap_en rises SHALL NOT be captured.
REQ-027 CAPTURE SHALL end on a vs rise, at which frame_done pulses, frame_err is updated and frame_cnt increments.
REQ-028 At the end of a frame, the FSM SHALL go to WAIT_VS.
REQ-029 If cap_en is still 1 at the end of a frame, the next vs fall SHALL re-enter CAPTURE (continuous capture).
REQ-030 cap_en falling mid-frame SHALL NOT truncate the frame; the frame SHALL complete and no new frame SHALL start.
REQ-031 cfg_done falling in any state SHALL force IDLE on the next cycle, force de_o to 0 and produce no frame_done.
REQ-032 The byte counter (12 bit) SHALL increment on each gated byte and clear on each href fall.
REQ-033 On an href fall, a byte count != H_BYTES SHALL set a sticky line-error flag.
REQ-034 The line counter (11 bit) SHALL increment on each href fall in CAPTURE.
REQ-035 At the end of a frame, frame_err SHALL equal (line-error flag OR line count != V_LINES); both counters and the line-error flag SHALL then clear.
REQ-036 The counters SHALL saturate at their maximum rather than wrap; saturation SHALL imply an error.
REQ-037 A simultaneous vs rise and href fall SHALL have the href fall processed first and included in the frame status.

Reset
REQ-038 On reset, state SHALL be IDLE and all counters and flags SHALL be 0.
REQ-039 On reset, vs_o, de_o, pdata_o, frame_start, frame_done, frame_err, frame_cnt and busy SHALL all be 0.
REQ-040 Reset assertion SHALL take effect immediately (asynchronous); deassertion SHALL take effect at the next pclk edge.

Structure
REQ-041 Package cmos_pkg SHALL hold the FSM state encoding and the default values of SKIP_FRAMES, H_BYTES and V_LINES.
REQ-042 A sub-module cmos_edge_det (1-bit register plus rise/fall outputs) SHALL be instantiated once each for vs and href.
REQ-043 The FSM and the counters SHALL live in cmos_capture_ctrl.

Verification (SKIP_FRAMES=2, H_BYTES=8, V_LINES=4)
REQ-044 Bench: cfg_done=1, cap_en=1, 4 correct frames -> frames 1-2 skipped with no de_o; frame 3 -> frame_start, 32 de_o cycles, frame_done with frame_err=0 and frame_cnt=1; frame 4 -> frame_cnt=2.
REQ-045 Bench: one line of 7 bytes in a captured frame -> frame_done with frame_err=1; next correct frame -> frame_err=0.
REQ-046 Bench: cap_en dropped after line 2 of a captured frame -> lines 3-4 still gated; frame_done asserted; no de_o in the following frame.
REQ-047 Bench: cfg_done dropped mid-CAPTURE -> de_o=0 the next cycle; no frame_done; after re-assertion, 2 frames are skipped again.
REQ-048 Bench: cap_en raised mid-frame -> no de_o until the following vs fall.
REQ-049 Bench: 256 captured frames -> frame_cnt wraps to 0; rst_n pulse mid-frame -> all outputs 0 immediately and state IDLE.
